// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start detection, LSB-first data capture,
// optional parity check, stop/break handling and a valid/ready output holding register.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | line idle, waiting for a low sample on a baud tick
// S_START      | start bit seen, counting to mid-bit to confirm it
// S_DATA       | sampling data bits at mid-bit, shifting in LSB first
// S_PARITY     | sampling the parity bit and comparing against the data
// S_STOP       | sampling the stop bit; frame completes on this sample
// S_BREAK_WAIT | stop bit was low; wait for the line to return high
module uart_rx_ctrl #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_baud_tick,
   input  logic                 i_serial_in,
   input  logic                 i_parity_en,
   input  logic                 i_parity_odd,
   input  logic                 i_rx_ready,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   output logic                 o_parity_error,
   output logic                 o_framing_error,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK_WAIT
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_tick_cnt;
   logic [BW-1:0]        r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_acc;
   logic                 r_par_en;
   logic                 r_par_odd;
   logic                 r_par_err;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_parity_error;
   logic                 r_framing_error;
   logic                 r_overrun;

   logic w_at_half;
   logic w_at_full;
   logic w_frame_done;
   logic w_can_load;

   assign w_at_half    = (r_tick_cnt == HALF_LAST);
   assign w_at_full    = (r_tick_cnt == FULL_LAST);
   assign w_frame_done = i_baud_tick && (r_state == S_STOP) && w_at_full;
   // A finished frame may replace the held word only if it is empty or being taken this cycle.
   assign w_can_load   = !r_rx_valid || i_rx_ready;

   assign o_rx_data       = r_rx_data;
   assign o_rx_valid      = r_rx_valid;
   assign o_parity_error  = r_parity_error;
   assign o_framing_error = r_framing_error;
   assign o_overrun       = r_overrun;
   assign o_busy          = (r_state != S_IDLE);

   // Receive FSM, bit counters and the output holding register.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state         <= S_IDLE;
         r_tick_cnt      <= '0;
         r_bit_idx       <= '0;
         r_shift         <= '0;
         r_par_acc       <= 1'b0;
         r_par_en        <= 1'b0;
         r_par_odd       <= 1'b0;
         r_par_err       <= 1'b0;
         r_rx_data       <= '0;
         r_rx_valid      <= 1'b0;
         r_parity_error  <= 1'b0;
         r_framing_error <= 1'b0;
         r_overrun       <= 1'b0;
      end else begin
         r_overrun <= 1'b0;

         if (r_rx_valid && i_rx_ready) begin
            r_rx_valid <= 1'b0;
         end

         if (w_frame_done) begin
            if (w_can_load) begin
               r_rx_data       <= r_shift;
               r_parity_error  <= r_par_err & r_par_en;
               r_framing_error <= !i_serial_in;
               r_rx_valid      <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end

         if (i_baud_tick) begin
            case (r_state)
               S_IDLE: begin
                  if (!i_serial_in) begin
                     r_state    <= S_START;
                     r_tick_cnt <= '0;
                  end
               end
               S_START: begin
                  if (w_at_half) begin
                     r_tick_cnt <= '0;
                     if (!i_serial_in) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_par_acc <= 1'b0;
                        r_par_err <= 1'b0;
                        r_par_en  <= i_parity_en;
                        r_par_odd <= i_parity_odd;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               S_DATA: begin
                  if (w_at_full) begin
                     r_tick_cnt <= '0;
                     r_shift    <= {i_serial_in, r_shift[DATA_BITS-1:1]};
                     r_par_acc  <= r_par_acc ^ i_serial_in;
                     if (r_bit_idx == BIT_LAST) begin
                        r_bit_idx <= '0;
                        r_state   <= r_par_en ? S_PARITY : S_STOP;
                     end else begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               S_PARITY: begin
                  if (w_at_full) begin
                     r_tick_cnt <= '0;
                     // Expected bit is data XOR (odd ? 1 : 0); flag any difference.
                     r_par_err  <= i_serial_in ^ r_par_acc ^ r_par_odd;
                     r_state    <= S_STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               S_STOP: begin
                  if (w_at_full) begin
                     r_tick_cnt <= '0;
                     r_state    <= i_serial_in ? S_IDLE : S_BREAK_WAIT;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               S_BREAK_WAIT: begin
                  if (i_serial_in) begin
                     r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state    <= S_IDLE;
                  r_tick_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule
